wom_reader: RTL and testbench
=============================

# wom_reader

Read-out engine for the vector CPU's write-only output memory (WOM), which the memory stage fills with result pixels. On a start pulse it reads a run of 32-bit result words from a synchronous-read RAM port and streams each word out as four bytes, LSB first, over a valid/ready byte interface toward the host link. It sits beside the CPU as the consumer of the WOM port that the pipeline only writes.

## Interface
- ADDR_W, 16, width of WOM word address and of word count
- DATA_W, 32, WOM word width; fixed at 32, four bytes per word
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched on accepted start
- word_count  in  ADDR_W  number of words to send; latched on accepted start
- busy  out  1  high from the accepted start through the DONE cycle
- done  out  1  one-cycle pulse at the end of a transfer
- mem_rd_en  out  1  WOM read strobe
- mem_addr  out  ADDR_W  WOM read address
- mem_rdata  in  DATA_W  WOM read data, valid the cycle after mem_rd_en
- tx_valid  out  1  byte available
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready at clk edge
- tx_data  out  8  byte value
- tx_last  out  1  marks the final byte of the transfer

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: if start=1, latch base_addr into addr_q, word_count into remain_q, then go to READ. If the latched count is 0, go directly to DONE and issue no reads.
- READ: drive mem_rd_en=1 and mem_addr=addr_q for exactly one cycle, then go to WAIT.
- WAIT: at the closing edge, capture mem_rdata into the 32-bit shift register, set byte_idx=0, decrement remain_q, increment addr_q modulo 2^ADDR_W, then go to SEND.
- SEND: tx_valid=1 and tx_data=shift[7:0].
  - On handshake: shift right 8 and increment byte_idx.
  - On the handshake of byte_idx=3: go to READ if remain_q≠0, else to DONE.
- tx_last=1 only in SEND when byte_idx=3 and remain_q=0.
- DONE: done=1 for one cycle, then return to IDLE.
- start is ignored in every state except IDLE; no queuing.
- Address wrap: addr_q increments modulo 2^ADDR_W (0xFFFF→0x0000 at the default width).
- Counting: remain_q is unsigned. The maximum word_count (2^ADDR_W−1) is legal.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, tx_valid=0, tx_data=0, tx_last=0, state=IDLE.
- Reset mid-transfer clears everything immediately. No done pulse, and the partial byte stream is abandoned.
- Every output is driven from registers or decoded from state only; there is no combinational path from tx_ready to any output.
- Start accepted at edge E0:
  - READ during E0→E1.
  - WAIT during E1→E2.
  - SEND from E2.
- With tx_ready held at 1, the four bytes of a word transfer on four consecutive edges.
- Minimum cost is 6 cycles per word: READ + WAIT + 4 SEND.
- For N≥1 words with no backpressure, done is high during cycle E(6N) to E(6N+1), and busy falls after E(6N+1).
- count=0: DONE during E0→E1, busy=1 for that one cycle, and no tx activity.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data, tx_last and state hold. tx_valid never drops mid-word.

## Test plan
- **Single word:** WOM[0x0010]=0xAABBCCDD, start with base=0x0010, count=1, tx_ready=1.
  - Expect mem_rd_en one cycle with addr 0x0010.
  - Expect bytes DD, CC, BB, AA on consecutive edges, with tx_last only on AA.
  - Expect done 6 cycles after the start edge, then busy=0.
- **Two words with backpressure:** WOM[0]=0x04030201, WOM[1]=0x08070605, count=2, tx_ready toggling 1,0,1,0.
  - Expect the stream 01..08 in order.
  - tx_data must stay stable during every ready=0 cycle.
  - tx_last only on 08; exactly 2 reads.
- **Zero count:** start with count=0.
  - Expect busy=1 for one cycle and done pulse at the next cycle.
  - No mem_rd_en and no tx_valid.
- **Address wrap:** base=0xFFFF, count=2.
  - Expect mem_addr sequence 0xFFFF then 0x0000 and 8 bytes transferred.
- **Start while busy:** pulse start again during SEND of a count=1 transfer.
  - Expect it to be ignored: one done pulse and 4 bytes only.
  - A start pulse after busy falls must launch a fresh transfer.
- **Reset mid-stream:** assert rst after byte 2 of a 3-word transfer.
  - All outputs go to 0 immediately and no done pulse is issued.
  - After release, a new start with count=1 behaves exactly as in the single-word scenario.

Source files
------------

// File: rtl/wom_reader_if.sv
// wom_reader_if: bundles the start/status, WOM read port and byte-stream
// signals of the WOM read-out engine.
//   master : the reader (drives status, memory strobe/address, byte stream)
//   slave  : the environment (drives start/config, read data, tx_ready)
interface wom_reader_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_last;

  modport master (
    input  start, base_addr, word_count, mem_rdata, tx_ready,
    output busy, done, mem_rd_en, mem_addr, tx_valid, tx_data, tx_last
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, tx_ready,
    input  busy, done, mem_rd_en, mem_addr, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/wom_reader.sv
// wom_reader: on a start pulse, reads word_count 32-bit words from the WOM
// starting at base_addr (synchronous-read port, data one cycle after the
// strobe) and streams each word as four bytes, LSB first, over valid/ready.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wom_reader_if.master (start/config, busy/done, WOM read port,
//              tx byte stream with tx_last on the final byte)
// All outputs are registers; tx_ready only affects next-state logic.
module wom_reader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  wom_reader_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic [DATA_W-1:0] shift_q;
  logic [1:0]        byte_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remain_q      <= '0;
      shift_q       <= '0;
      byte_idx_q    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.tx_last   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            addr_q   <= bus.base_addr;
            remain_q <= bus.word_count;
            bus.busy <= 1'b1;
            if (bus.word_count == '0) begin
              state_q  <= StDone;
              bus.done <= 1'b1;
            end else begin
              state_q       <= StRead;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= bus.base_addr;
            end
          end
        end

        StRead: begin
          bus.mem_rd_en <= 1'b0;
          state_q       <= StWait;
        end

        StWait: begin
          // Read data is valid now; present byte 0 straight away.
          shift_q      <= bus.mem_rdata;
          bus.tx_data  <= bus.mem_rdata[7:0];
          bus.tx_valid <= 1'b1;
          bus.tx_last  <= 1'b0;
          byte_idx_q   <= 2'd0;
          remain_q     <= remain_q - AddrOne;
          addr_q       <= addr_q + AddrOne;
          state_q      <= StSend;
        end

        StSend: begin
          // tx_valid is always high here, so tx_ready alone is the handshake.
          if (bus.tx_ready) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            shift_q    <= shift_q >> 8;
            if (byte_idx_q == 2'd3) begin
              bus.tx_valid <= 1'b0;
              bus.tx_data  <= '0;
              bus.tx_last  <= 1'b0;
              if (remain_q != '0) begin
                state_q       <= StRead;
                bus.mem_rd_en <= 1'b1;
                bus.mem_addr  <= addr_q;
              end else begin
                state_q  <= StDone;
                bus.done <= 1'b1;
              end
            end else begin
              bus.tx_data <= shift_q[15:8];
              // Next byte is byte 3 of the final word.
              bus.tx_last <= (byte_idx_q == 2'd2) && (remain_q == '0);
            end
          end
        end

        StDone: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wom_reader.sv
module tb_wom_reader;

  logic clk;
  logic rst;

  wom_reader_if #(.ADDR_W(16), .DATA_W(32)) bus_if ();

  wom_reader #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // WOM model: synchronous read, data valid the cycle after the strobe.
  logic [31:0] wom [logic [15:0]];

  function automatic logic [31:0] wom_read(input logic [15:0] a);
    if (wom.exists(a)) return wom[a];
    return 32'hDEAD0000 | {16'h0, a};
  endfunction

  initial begin
    bus_if.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus_if.mem_rd_en) bus_if.mem_rdata <= wom_read(bus_if.mem_addr);
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples on the falling edge what the next rising edge will do.
  logic [7:0]  byte_q [$];
  logic        last_q [$];
  logic [15:0] rd_q [$];
  int          rd_cyc_q [$];
  int          done_cnt, done_cyc, busy_cnt, valid_seen, stable_err;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic clear_mon();
    byte_q.delete();
    last_q.delete();
    rd_q.delete();
    rd_cyc_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    busy_cnt   = 0;
    valid_seen = 0;
    stable_err = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && (!bus_if.tx_valid || bus_if.tx_data !== prev_data ||
                           bus_if.tx_last !== prev_last))
          stable_err++;
        prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
        prev_data  = bus_if.tx_data;
        prev_last  = bus_if.tx_last;
        if (bus_if.tx_valid) valid_seen++;
        if (bus_if.busy) busy_cnt++;
        if (bus_if.tx_valid && bus_if.tx_ready) begin
          byte_q.push_back(bus_if.tx_data);
          last_q.push_back(bus_if.tx_last);
        end
        if (bus_if.mem_rd_en) begin
          rd_q.push_back(bus_if.mem_addr);
          rd_cyc_q.push_back(cyc);
        end
        if (bus_if.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // tx_ready: held high, or toggling every cycle when bp_mode is set.
  logic bp_mode = 1'b0;
  initial begin
    bus_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) bus_if.tx_ready = ~bus_if.tx_ready;
      else         bus_if.tx_ready = 1'b1;
    end
  end

  int start_cyc;

  task automatic launch(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk);
    #1;
    bus_if.base_addr  = b;
    bus_if.word_count = n;
    bus_if.start      = 1'b1;
    @(posedge clk);
    #1;
    start_cyc    = cyc;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  logic [31:0] exp_words [$];

  task automatic check_stream(input string tag);
    int n;
    n = 4 * exp_words.size();
    check({tag, "_nbytes"}, byte_q.size(), n);
    for (int i = 0; i < n && i < byte_q.size(); i++) begin
      logic [31:0] w;
      w = exp_words[i / 4] >> (8 * (i % 4));
      check({tag, "_byte"}, {24'h0, byte_q[i]}, {24'h0, w[7:0]});
      check({tag, "_last"}, {31'h0, last_q[i]}, {31'h0, (i == n - 1)});
    end
  endtask

  task automatic outputs_zero(input string tag);
    check(tag, {bus_if.busy, bus_if.done, bus_if.mem_rd_en, bus_if.tx_valid, bus_if.tx_last,
                bus_if.tx_data, bus_if.mem_addr}, 32'h0);
  endtask

  task automatic single_word(input string tag);
    clear_mon();
    launch(16'h0010, 16'd1);
    wait_done(40);
    check({tag, "_nreads"}, rd_q.size(), 1);
    if (rd_q.size() > 0) begin
      check({tag, "_rdaddr"}, {16'h0, rd_q[0]}, 32'h0010);
      check({tag, "_rdcyc"}, rd_cyc_q[0] - start_cyc, 0);
    end
    exp_words.delete();
    exp_words.push_back(32'hAABBCCDD);
    check_stream(tag);
    check({tag, "_donecyc"}, done_cyc - start_cyc, 6);
    check({tag, "_ndone"}, done_cnt, 1);
    check({tag, "_busycyc"}, busy_cnt, 7);
    check({tag, "_busy_end"}, {31'h0, bus_if.busy}, 32'h0);
  endtask

  initial begin
    wom[16'h0010] = 32'hAABBCCDD;
    wom[16'h0011] = 32'h55667788;
    wom[16'h0000] = 32'h04030201;
    wom[16'h0001] = 32'h08070605;
    wom[16'hFFFF] = 32'h11223344;
    wom[16'h0020] = 32'h1A2B3C4D;
    wom[16'h0021] = 32'h5E6F7081;
    wom[16'h0022] = 32'h92A3B4C5;

    rst               = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.base_addr  = '0;
    bus_if.word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset_outputs");
    rst = 1'b0;

    single_word("single");

    // Two words under alternating backpressure.
    clear_mon();
    bp_mode = 1'b1;
    launch(16'h0000, 16'd2);
    wait_done(80);
    bp_mode = 1'b0;
    exp_words.delete();
    exp_words.push_back(32'h04030201);
    exp_words.push_back(32'h08070605);
    check_stream("bp");
    check("bp_nreads", rd_q.size(), 2);
    check("bp_stable", stable_err, 0);
    check("bp_ndone", done_cnt, 1);

    // Zero count.
    clear_mon();
    launch(16'h0040, 16'd0);
    wait_done(10);
    check("zero_ndone", done_cnt, 1);
    check("zero_donecyc", done_cyc - start_cyc, 0);
    check("zero_busycyc", busy_cnt, 1);
    check("zero_nreads", rd_q.size(), 0);
    check("zero_valid", valid_seen, 0);

    // Address wrap.
    clear_mon();
    launch(16'hFFFF, 16'd2);
    wait_done(40);
    check("wrap_nreads", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("wrap_addr0", {16'h0, rd_q[0]}, 32'h0000FFFF);
      check("wrap_addr1", {16'h0, rd_q[1]}, 32'h00000000);
    end
    exp_words.delete();
    exp_words.push_back(32'h11223344);
    exp_words.push_back(32'h04030201);
    check_stream("wrap");

    // Start while busy is ignored.
    clear_mon();
    launch(16'h0010, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    bus_if.base_addr  = 16'h0000;
    bus_if.word_count = 16'd5;
    bus_if.start      = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    wait_done(40);
    repeat (6) @(posedge clk);
    check("busy_start_ndone", done_cnt, 1);
    check("busy_start_nbytes", byte_q.size(), 4);
    check("busy_start_nreads", rd_q.size(), 1);

    clear_mon();
    launch(16'h0011, 16'd1);
    wait_done(40);
    exp_words.delete();
    exp_words.push_back(32'h55667788);
    check_stream("relaunch");

    // Reset in the middle of a three-word stream.
    clear_mon();
    launch(16'h0020, 16'd3);
    for (int i = 0; i < 50 && byte_q.size() < 2; i++) @(negedge clk);
    check("rst_mid_reached", byte_q.size(), 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    outputs_zero("rst_mid_outputs");
    repeat (3) @(posedge clk);
    check("rst_mid_ndone", done_cnt, 0);
    #1;
    rst = 1'b0;
    single_word("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
